// File: rtl/elastic_reg_pipe_pkg.sv
// Shared types and helpers for the elastic register pipeline.
package elastic_reg_pipe_pkg;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2,
    OCC_CLR  = 2'd3
  } occ_op_e;

  // Flush wins; simultaneous input and output handshakes cancel out.
  function automatic occ_op_e occ_op(input logic flush, input logic in_hs, input logic out_hs);
    if (flush) return OCC_CLR;
    if (in_hs && !out_hs) return OCC_INC;
    if (out_hs && !in_hs) return OCC_DEC;
    return OCC_HOLD;
  endfunction

endpackage

// File: rtl/elastic_reg_pipe_stage.sv
// One pipeline stage: a valid bit plus a W-bit data register.
module elastic_reg_stage #(
  parameter int unsigned   W         = 8,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (load) begin
      valid <= up_valid;
      // Bubbles pass through the valid bit only; the data register keeps its last word.
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and occupancy count.
module elastic_reg_pipe
  import elastic_reg_pipe_pkg::*;
#(
  parameter int unsigned   W         = 8,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [W-1:0]  RESET_VAL = '0,
  parameter int unsigned   CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] up_v;
  logic [W-1:0]     d    [DEPTH];
  logic [W-1:0]     up_d [DEPTH];
  logic             in_hs;
  logic             out_hs;

  // Advance chain: a stage may load if it is empty or everything downstream moves.
  always_comb begin : adv_chain
    logic a;
    a              = !v[DEPTH-1] || out_ready;
    adv            = '0;
    adv[DEPTH-1]   = a;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      a      = !v[k] || a;
      adv[k] = a;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_v[k] = in_valid;
      assign up_d[k] = in_data;
    end else begin : g_body
      assign up_v[k] = v[k-1];
      assign up_d[k] = d[k-1];
    end

    elastic_reg_stage #(
      .W         (W),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (adv[k]),
      .up_valid (up_v[k]),
      .up_data  (up_d[k]),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  assign in_ready  = adv[0] && !flush && !rst;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Occupancy tracks handshakes rather than recounting valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      unique case (occ_op(flush, in_hs, out_hs))
        OCC_CLR:  occupancy <= '0;
        OCC_INC:  occupancy <= occupancy + CW'(1);
        OCC_DEC:  occupancy <= occupancy - CW'(1);
        default:  occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Scoreboard bench for elastic_reg_pipe: directed scenarios plus random traffic against a FIFO model.
module tb_elastic_reg_pipe;

  localparam int unsigned  W         = 8;
  localparam int unsigned  DEPTH     = 4;
  localparam int unsigned  CW        = $clog2(DEPTH + 1);
  localparam logic [W-1:0] RESET_VAL = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: words accepted but not yet delivered, oldest first.
  logic [W-1:0] q[$];

  elastic_reg_pipe #(
    .W         (W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples pre-edge values at every clock edge and updates the model.
  task automatic monitor();
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_data = '0;
    logic [W-1:0] exp_w;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        stall_prev = 1'b0;
        continue;
      end
      chk("in_ready", 32'(in_ready),
          32'(!flush && ((q.size() < int'(DEPTH)) || out_ready)));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      if (q.size() == 0) chk("empty_out_valid", 32'(out_valid), 32'd0);
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_w = q.pop_front();
          chk("out_data", 32'(out_data), 32'(exp_w));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(in_data);
      stall_prev = out_valid && !out_ready && !flush;
      stall_data = out_data;
    end
  endtask

  initial begin
    int p;
    logic acc;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset asserted mid-period takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(RESET_VAL));
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    fork
      monitor();
    join_none
    tick();

    // Streaming with latency check.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i + 1);
      tick();
      if (i == 2) chk("stream_not_yet", 32'(out_valid), 32'd0);
      if (i >= 3) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_data", 32'(out_data), 32'(i - 2));
        chk("stream_occ", 32'(occupancy), 32'd4);
      end
    end
    in_valid = 1'b0;
    repeat (6) tick();

    // Fill under stall.
    out_ready = 1'b0;
    p = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h10 + p);
      #1;
      acc = in_ready;
      chk("fill_in_ready", 32'(acc), 32'(c < 4));
      tick();
      if (acc) p++;
    end
    chk("fill_occ", 32'(occupancy), 32'd4);
    chk("fill_out_data", 32'(out_data), 32'h10);

    // Full pass-through.
    in_data   = W'(8'h10 + p);
    out_ready = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_next", 32'(out_data), 32'h11);
    in_valid = 1'b0;
    repeat (6) tick();

    // Bubble collapse.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h20; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'h21; tick();
    in_valid = 1'b0; tick(); tick();
    chk("bubble_occ", 32'(occupancy), 32'd2);
    chk("bubble_head", 32'(out_data), 32'h20);
    out_ready = 1'b1;
    tick();
    chk("bubble_second_valid", 32'(out_valid), 32'd1);
    chk("bubble_second_data", 32'(out_data), 32'h21);
    tick();
    chk("bubble_drained", 32'(out_valid), 32'd0);

    // Flush with words in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'(8'h30 + i); tick();
    end
    flush = 1'b1; in_data = 8'h33;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'(RESET_VAL));
    tick();

    // Mid-stream asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'(8'h40 + i); tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'(RESET_VAL));
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_release_ready", 32'(in_ready), 32'd1);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 3);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    chk("final_occ", 32'(occupancy), 32'd0);
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
